// File: rtl/read_master.sv
// Avalon-MM DDR3 read master: fetches LENGTH samples from BASE by STEP into a
// small FIFO and replays them as a RATE-paced stream of one-cycle pulses.
module read_master #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ddr_waitrequest,
    input  logic        ddr_readdatavalid,
    input  logic [15:0] ddr_readdata,
    output logic [15:0] ddr_addr,
    output logic        ddr_read,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    input  logic [2:0]  addr,
    input  logic        read,
    input  logic        write,
    output logic [15:0] d_out,
    output logic        v_out
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int AW1 = AW + 1;
    localparam logic [AW:0] FULL_CNT = AW1'(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_DRAIN, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [15:0]   base_q, len_q, step_q, rate_q;
    logic [15:0]   sh_len_q, sh_step_q, sh_rate_q;
    logic [15:0]   addr_q, issued_q, emitted_q, rc_q;
    logic [15:0]   dout_q, rdata_q, csr_rd;
    logic          vout_q;
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   cnt_q;
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic          soft_rst, start, start_ok, busy, done, accept, push, pop;

    assign soft_rst = write && (addr == 3'd6);
    assign start    = write && (addr == 3'd4);
    assign busy     = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_DRAIN);
    assign done     = (state_q == S_DONE);
    assign start_ok = start && !busy;
    // Issue is gated on a free slot, so the single outstanding read always fits.
    assign ddr_read = (state_q == S_FETCH) && (cnt_q != FULL_CNT);
    assign accept   = ddr_read && !ddr_waitrequest;
    // Data arriving outside WAIT belongs to a read abandoned by soft reset.
    assign push     = (state_q == S_WAIT) && ddr_readdatavalid;
    assign pop      = (rc_q == 16'd0) && (cnt_q != '0);

    assign ddr_addr = addr_q;
    assign d_out    = dout_q;
    assign v_out    = vout_q;
    assign readdata = rdata_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = (len_q == 16'd0) ? S_DONE : S_FETCH;
            S_FETCH:        if (accept) state_d = S_WAIT;
            S_WAIT:         if (push) state_d = (issued_q < sh_len_q) ? S_FETCH : S_DRAIN;
            S_DRAIN:        if (emitted_q == sh_len_q) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        csr_rd = 16'hDEAD;
        case (addr)
            3'd0:       csr_rd = base_q;
            3'd1:       csr_rd = len_q;
            3'd2:       csr_rd = step_q;
            3'd3:       csr_rd = rate_q;
            3'd4, 3'd6: csr_rd = 16'd0;
            3'd5:       csr_rd = {14'd0, busy, done};
            default:    csr_rd = 16'hDEAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= ddr_readdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q <= '0; len_q <= '0; step_q <= 16'd1; rate_q <= '0;
            sh_len_q <= '0; sh_step_q <= 16'd1; sh_rate_q <= '0;
            addr_q <= '0; issued_q <= '0; emitted_q <= '0; rc_q <= '0;
            dout_q <= '0; vout_q <= 1'b0; rdata_q <= '0;
            wptr_q <= '0; rptr_q <= '0; cnt_q <= '0;
        end else if (soft_rst) begin
            state_q <= S_IDLE;
            base_q <= '0; len_q <= '0; step_q <= 16'd1; rate_q <= '0;
            sh_len_q <= '0; sh_step_q <= 16'd1; sh_rate_q <= '0;
            addr_q <= '0; issued_q <= '0; emitted_q <= '0; rc_q <= '0;
            dout_q <= '0; vout_q <= 1'b0; rdata_q <= '0;
            wptr_q <= '0; rptr_q <= '0; cnt_q <= '0;
        end else begin
            state_q <= state_d;
            rdata_q <= read ? csr_rd : 16'd0;
            if (write) begin
                case (addr)
                    3'd0:    base_q <= writedata;
                    3'd1:    len_q  <= writedata;
                    3'd2:    step_q <= writedata;
                    3'd3:    rate_q <= writedata;
                    default: ;
                endcase
            end
            if (state_q == S_IDLE) addr_q <= base_q;
            if (accept) issued_q <= issued_q + 16'd1;
            if (push) begin
                addr_q <= addr_q + sh_step_q;
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q    <= rptr_q + AW'(1);
                dout_q    <= mem_q[rptr_q];
                vout_q    <= 1'b1;
                rc_q      <= sh_rate_q;
                emitted_q <= emitted_q + 16'd1;
            end else begin
                vout_q <= 1'b0;
                if (rc_q != 16'd0) rc_q <= rc_q - 16'd1;
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + AW1'(1);
                2'b01:   cnt_q <= cnt_q - AW1'(1);
                default: ;
            endcase
            // Transfer parameters are latched here so CSR writes during a run wait for the next START.
            if (start_ok) begin
                sh_len_q  <= len_q;
                sh_step_q <= step_q;
                sh_rate_q <= rate_q;
                addr_q    <= base_q;
                issued_q  <= '0;
                emitted_q <= '0;
                rc_q      <= '0;
            end
        end
    end
endmodule

// File: tb/tb_read_master.sv
// Directed bench for read_master: a reactive DDR3 slave model feeds known memory
// contents, and each scenario checks addresses, stream data/timing and CSRs.
module tb_read_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ddr_waitrequest = 1'b0;
    logic        ddr_readdatavalid = 1'b0;
    logic [15:0] ddr_readdata = 16'd0;
    logic [15:0] ddr_addr;
    logic        ddr_read;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic [2:0]  addr = 3'd0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [15:0] d_out;
    logic        v_out;

    int nvec = 0, nerr = 0, cyc = 0;
    int delay = 0, wr_mode = 0, pcnt = 0;
    bit chk_stall = 1'b1, pend = 1'b0, stall_prev = 1'b0;
    logic [15:0] paddr = 16'd0, stall_addr = 16'd0, rd = 16'd0;
    logic [15:0] addr_q[$];
    logic [15:0] vq[$];
    int tq[$];

    read_master #(.FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .ddr_waitrequest(ddr_waitrequest),
        .ddr_readdatavalid(ddr_readdatavalid), .ddr_readdata(ddr_readdata),
        .ddr_addr(ddr_addr), .ddr_read(ddr_read), .writedata(writedata),
        .readdata(readdata), .addr(addr), .read(read), .write(write),
        .d_out(d_out), .v_out(v_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {~a[7:0], a[7:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // DDR3 slave: one outstanding read, programmable latency and stall pattern.
    always @(negedge clk) begin
        ddr_readdatavalid = 1'b0;
        if (rst) pend = 1'b0;
        else if (pend) begin
            if (pcnt == 0) begin
                ddr_readdatavalid = 1'b1;
                ddr_readdata = memf(paddr);
                pend = 1'b0;
            end else pcnt--;
        end
        if (stall_prev && chk_stall) begin
            check("stall_read", {31'd0, ddr_read}, 32'd1);
            check("stall_addr", {16'd0, ddr_addr}, {16'd0, stall_addr});
        end
        case (wr_mode)
            1:       ddr_waitrequest = !ddr_waitrequest && ($urandom_range(0, 1) == 1);
            2:       ddr_waitrequest = 1'b1;
            default: ddr_waitrequest = 1'b0;
        endcase
        stall_prev = ddr_read && ddr_waitrequest;
        stall_addr = ddr_addr;
        if (ddr_read && !ddr_waitrequest && !rst) begin
            addr_q.push_back(ddr_addr);
            pend = 1'b1; pcnt = delay; paddr = ddr_addr;
        end
        if (v_out) begin
            vq.push_back(d_out);
            tq.push_back(cyc);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic csr_write(input logic [2:0] a, input logic [15:0] d);
        @(negedge clk); write = 1'b1; addr = a; writedata = d;
        @(negedge clk); write = 1'b0;
    endtask

    task automatic csr_read(input logic [2:0] a, output logic [15:0] d);
        @(negedge clk); read = 1'b1; addr = a;
        @(negedge clk); read = 1'b0; d = readdata;
    endtask

    task automatic start_xfer(input logic [15:0] b, input logic [15:0] l,
                              input logic [15:0] s, input logic [15:0] r);
        csr_write(3'd0, b); csr_write(3'd1, l); csr_write(3'd2, s); csr_write(3'd3, r);
        addr_q.delete(); vq.delete(); tq.delete();
        csr_write(3'd4, 16'd1);
    endtask

    task automatic wait_samples(input int n, input int budget, input string tag);
        int k = 0;
        while (vq.size() < n && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(vq.size()), 32'(n));
    endtask

    task automatic wait_fetch(input int budget, input string tag);
        int k = 0;
        while (addr_q.size() < 1 && k < budget) begin @(negedge clk); k++; end
        check(tag, 32'(addr_q.size() >= 1), 32'd1);
    endtask

    task automatic check_stream(input string tag, input logic [15:0] base,
                                input logic [15:0] step, input int len);
        logic [15:0] a, oa, od;
        a = base;
        for (int i = 0; i < len; i++) begin
            oa = (i < addr_q.size()) ? addr_q[i] : 16'hxxxx;
            od = (i < vq.size()) ? vq[i] : 16'hxxxx;
            check($sformatf("%s_addr%0d", tag, i), {16'd0, oa}, {16'd0, a});
            check($sformatf("%s_data%0d", tag, i), {16'd0, od}, {16'd0, memf(a)});
            a = a + step;
        end
    endtask

    initial begin
        // Reset state
        idle(3);
        check("rst_ddr_read", {31'd0, ddr_read}, 32'd0);
        check("rst_ddr_addr", {16'd0, ddr_addr}, 32'd0);
        check("rst_v_out", {31'd0, v_out}, 32'd0);
        check("rst_d_out", {16'd0, d_out}, 32'd0);
        check("rst_readdata", {16'd0, readdata}, 32'd0);
        rst = 1'b0;
        csr_read(3'd0, rd); check("def_base", {16'd0, rd}, 32'd0);
        csr_read(3'd1, rd); check("def_len", {16'd0, rd}, 32'd0);
        csr_read(3'd2, rd); check("def_step", {16'd0, rd}, 32'd1);
        csr_read(3'd3, rd); check("def_rate", {16'd0, rd}, 32'd0);
        csr_read(3'd5, rd); check("def_status", {16'd0, rd}, 32'd0);
        csr_read(3'd7, rd); check("unmapped", {16'd0, rd}, 32'hDEAD);
        idle(1); check("rdata_clear", {16'd0, readdata}, 32'd0);

        // 1: basic linear fetch
        start_xfer(16'h0010, 16'd4, 16'd1, 16'd0);
        wait_samples(4, 200, "t1_count");
        idle(5);
        check_stream("t1", 16'h0010, 16'd1, 4);
        check("t1_nreads", 32'(addr_q.size()), 32'd4);
        csr_read(3'd5, rd); check("t1_status", {16'd0, rd}, 32'd1);

        // 2: address wrap-around
        start_xfer(16'hFFFD, 16'd3, 16'd3, 16'd0);
        wait_samples(3, 200, "t2_count");
        idle(5);
        check_stream("t2", 16'hFFFD, 16'd3, 3);

        // 3: RATE=3 pacing under random stalls
        wr_mode = 1;
        start_xfer(16'h0100, 16'd5, 16'd2, 16'd3);
        wait_samples(5, 300, "t3_count");
        idle(5);
        wr_mode = 0;
        check_stream("t3", 16'h0100, 16'd2, 5);
        for (int i = 1; i < 5; i++)
            check($sformatf("t3_gap%0d", i), 32'((i < tq.size()) ? tq[i] - tq[i-1] : -1), 32'd4);

        // 4: long read latency
        delay = 20;
        start_xfer(16'h0200, 16'd5, 16'd1, 16'd0);
        wait_samples(5, 400, "t4_count");
        idle(5);
        check_stream("t4", 16'h0200, 16'd1, 5);

        // 5a: START and BASE writes while busy do not disturb the run
        delay = 4;
        start_xfer(16'h0020, 16'd3, 16'd1, 16'd0);
        wait_fetch(50, "t5_fetch");
        csr_write(3'd0, 16'h0080);
        csr_write(3'd4, 16'd1);
        wait_samples(3, 200, "t5_count");
        idle(10);
        check("t5_total", 32'(vq.size()), 32'd3);
        check_stream("t5", 16'h0020, 16'd1, 3);
        csr_read(3'd0, rd); check("t5_base_rb", {16'd0, rd}, 32'h0080);
        delay = 0;

        // 5b: zero length completes immediately
        start_xfer(16'h0050, 16'd0, 16'd1, 16'd0);
        csr_read(3'd5, rd); check("t5_len0_status", {16'd0, rd}, 32'd1);
        idle(10);
        check("t5_len0_reads", 32'(addr_q.size()), 32'd0);
        check("t5_len0_vout", 32'(vq.size()), 32'd0);

        // 6: soft reset while waiting for data
        delay = 10;
        start_xfer(16'h0030, 16'd4, 16'd1, 16'd0);
        wait_fetch(50, "t6_fetch");
        idle(2);
        csr_write(3'd6, 16'd0);
        idle(15);
        check("t6_vout", 32'(vq.size()), 32'd0);
        check("t6_ddr_read", {31'd0, ddr_read}, 32'd0);
        check("t6_d_out", {16'd0, d_out}, 32'd0);
        csr_read(3'd0, rd); check("t6_base", {16'd0, rd}, 32'd0);
        csr_read(3'd1, rd); check("t6_len", {16'd0, rd}, 32'd0);
        csr_read(3'd2, rd); check("t6_step", {16'd0, rd}, 32'd1);
        csr_read(3'd3, rd); check("t6_rate", {16'd0, rd}, 32'd0);
        csr_read(3'd5, rd); check("t6_status", {16'd0, rd}, 32'd0);
        delay = 0;

        // 6b: async reset while stalled in FETCH
        wr_mode = 2;
        start_xfer(16'h0040, 16'd4, 16'd1, 16'd0);
        idle(3);
        check("t6b_pre_read", {31'd0, ddr_read}, 32'd1);
        check("t6b_pre_addr", {16'd0, ddr_addr}, 32'h0040);
        chk_stall = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6b_ddr_read", {31'd0, ddr_read}, 32'd0);
        check("t6b_ddr_addr", {16'd0, ddr_addr}, 32'd0);
        check("t6b_v_out", {31'd0, v_out}, 32'd0);
        check("t6b_d_out", {16'd0, d_out}, 32'd0);
        check("t6b_readdata", {16'd0, readdata}, 32'd0);
        @(negedge clk); rst = 1'b0; wr_mode = 0;
        csr_read(3'd5, rd); check("t6b_status", {16'd0, rd}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
